vend_ctrl_multi: RTL and testbench

//  Parametrised N-item vending controller: accumulates coin credit, lets the user

---
 rtl/vend_ctrl_multi.sv | 172 +++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// Parametrised N-item vending controller: synchronised coin/button edges are latched
// until the next event tick, where a single prioritised event updates credit/selection.
module vend_ctrl_multi #(
    parameter int                         N_ITEMS    = 5,
    parameter int                         PRICE_W    = 5,
    parameter logic [N_ITEMS*PRICE_W-1:0] PRICES     = {5'd8, 5'd10, 5'd6, 5'd5, 5'd7},
    parameter int                         CREDIT_W   = 7,
    parameter int                         CREDIT_MAX = 99,
    parameter logic [27:0]                COIN_VALS  = {7'd20, 7'd10, 7'd5, 7'd1},
    parameter int                         TICK_DIV   = 10000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 coin,
    input  logic                       btn_l,
    input  logic                       btn_r,
    input  logic                       btn_c,
    input  logic                       btn_ret,
    output logic [$clog2(N_ITEMS)-1:0] sel_idx,
    output logic [PRICE_W-1:0]         sel_price,
    output logic [CREDIT_W-1:0]        credit,
    output logic [N_ITEMS-1:0]         avail,
    output logic                       vend_valid,
    output logic [$clog2(N_ITEMS)-1:0] vend_idx,
    output logic                       deny,
    output logic                       coin_rej,
    output logic                       chg_valid,
    output logic [CREDIT_W-1:0]        chg_amt
);

    localparam int                IDX_W        = $clog2(N_ITEMS);
    localparam int                CNT_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(N_ITEMS - 1);
    localparam logic [CREDIT_W:0] CREDIT_LIMIT = (CREDIT_W + 1)'(CREDIT_MAX);

    // Event bit order: [3:0] coins, [4] left, [5] right, [6] buy, [7] return
    logic [7:0]          raw_in;
    logic [7:0]          sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [7:0]          flag_q, flag_d;
    logic [7:0]          pend;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tick;
    logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [N_ITEMS-1:0]  avail_q, avail_d;
    logic                vend_valid_q, vend_valid_d;
    logic [IDX_W-1:0]    vend_idx_q, vend_idx_d;
    logic                deny_q, deny_d;
    logic                coin_rej_q, coin_rej_d;
    logic                chg_valid_q, chg_valid_d;
    logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
    logic                coin_hit;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [PRICE_W-1:0]  price_sel;
    logic [CREDIT_W-1:0] price_ext;

    assign raw_in = {btn_ret, btn_c, btn_r, btn_l, coin};

    always_comb begin
        sync1_d      = raw_in;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        // A flag raised in the same cycle as a tick is consumed by that tick
        pend         = flag_q | (sync2_q & ~sync3_q);
        tick         = (cnt_q == TICK_LAST);
        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        flag_d       = tick ? '0 : pend;
        credit_d     = credit_q;
        sel_idx_d    = sel_idx_q;
        vend_valid_d = 1'b0;
        vend_idx_d   = '0;
        deny_d       = 1'b0;
        coin_rej_d   = 1'b0;
        chg_valid_d  = 1'b0;
        chg_amt_d    = '0;
        avail_d      = '0;

        price_sel = PRICES[sel_idx_q*PRICE_W +: PRICE_W];
        price_ext = CREDIT_W'(price_sel);

        // Scan downward so the lowest-index pending coin is the one kept
        coin_hit = 1'b0;
        coin_val = '0;
        for (int k = 3; k >= 0; k--) begin
            if (pend[k]) begin
                coin_hit = 1'b1;
                coin_val = (CREDIT_W + 1)'(COIN_VALS[k*7 +: 7]);
            end
        end
        coin_sum = {1'b0, credit_q} + coin_val;

        for (int i = 0; i < N_ITEMS; i++) begin
            avail_d[i] = (credit_q >= CREDIT_W'(PRICES[i*PRICE_W +: PRICE_W]));
        end

        if (tick) begin
            if (pend[7]) begin
                if (credit_q != '0) begin
                    chg_valid_d = 1'b1;
                    chg_amt_d   = credit_q;
                    credit_d    = '0;
                end
            end else if (pend[6]) begin
                if (credit_q >= price_ext) begin
                    vend_valid_d = 1'b1;
                    vend_idx_d   = sel_idx_q;
                    credit_d     = credit_q - price_ext;
                end else begin
                    deny_d = 1'b1;
                end
            end else if (coin_hit) begin
                if (coin_sum <= CREDIT_LIMIT) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                end else begin
                    coin_rej_d = 1'b1;
                end
            end else if (pend[4] && !pend[5]) begin
                sel_idx_d = (sel_idx_q == '0) ? IDX_LAST : sel_idx_q - IDX_W'(1);
            end else if (pend[5] && !pend[4]) begin
                sel_idx_d = (sel_idx_q == IDX_LAST) ? '0 : sel_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            flag_q       <= '0;
            cnt_q        <= '0;
            sel_idx_q    <= '0;
            credit_q     <= '0;
            avail_q      <= '0;
            vend_valid_q <= 1'b0;
            vend_idx_q   <= '0;
            deny_q       <= 1'b0;
            coin_rej_q   <= 1'b0;
            chg_valid_q  <= 1'b0;
            chg_amt_q    <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            flag_q       <= flag_d;
            cnt_q        <= cnt_d;
            sel_idx_q    <= sel_idx_d;
            credit_q     <= credit_d;
            avail_q      <= avail_d;
            vend_valid_q <= vend_valid_d;
            vend_idx_q   <= vend_idx_d;
            deny_q       <= deny_d;
            coin_rej_q   <= coin_rej_d;
            chg_valid_q  <= chg_valid_d;
            chg_amt_q    <= chg_amt_d;
        end
    end

    assign sel_idx    = sel_idx_q;
    assign sel_price  = price_sel;
    assign credit     = credit_q;
    assign avail      = avail_q;
    assign vend_valid = vend_valid_q;
    assign vend_idx   = vend_idx_q;
    assign deny       = deny_q;
    assign coin_rej   = coin_rej_q;
    assign chg_valid  = chg_valid_q;
    assign chg_amt    = chg_amt_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi with TICK_DIV=1 and default prices/coins.
// Item i sits at PRICES[i*5 +: 5], so item prices are 7,5,6,10,8; coins are 1,5,10,20.
module tb_vend_ctrl_multi;

    logic       clk;
    logic       rst;
    logic [3:0] coin;
    logic       btn_l, btn_r, btn_c, btn_ret;
    logic [2:0] sel_idx;
    logic [4:0] sel_price;
    logic [6:0] credit;
    logic [4:0] avail;
    logic       vend_valid;
    logic [2:0] vend_idx;
    logic       deny;
    logic       coin_rej;
    logic       chg_valid;
    logic [6:0] chg_amt;

    int pass_count = 0;
    int fail_count = 0;

    vend_ctrl_multi #(.TICK_DIV(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin       (coin),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .btn_c      (btn_c),
        .btn_ret    (btn_ret),
        .sel_idx    (sel_idx),
        .sel_price  (sel_price),
        .credit     (credit),
        .avail      (avail),
        .vend_valid (vend_valid),
        .vend_idx   (vend_idx),
        .deny       (deny),
        .coin_rej   (coin_rej),
        .chg_valid  (chg_valid),
        .chg_amt    (chg_amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            pass_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives {ret, c, r, l, coin[3:0]} high for one clock, returns just after the executing tick
    task automatic apply_stimulus(input logic [7:0] v);
        @(negedge clk);
        {btn_ret, btn_c, btn_r, btn_l, coin} = v;
        @(negedge clk);
        {btn_ret, btn_c, btn_r, btn_l, coin} = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {btn_ret, btn_c, btn_r, btn_l, coin} = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_credit", credit, 0);
        check_output("rst_sel_idx", sel_idx, 0);
        check_output("rst_sel_price", sel_price, 7);
        check_output("rst_avail", avail, 0);
        check_output("rst_pulses", {vend_valid, deny, coin_rej, chg_valid}, 0);
        @(negedge clk);
        rst = 1'b1;

        apply_stimulus(8'h02);
        check_output("coin5_credit", credit, 5);
        next_cycle();
        check_output("coin5_avail", avail, 5'b00010);
        apply_stimulus(8'h02);
        check_output("coin5x2_credit", credit, 10);
        next_cycle();
        check_output("coin10_avail", avail, 5'b11111);

        apply_stimulus(8'h40);
        check_output("buy0_valid", vend_valid, 1);
        check_output("buy0_idx", vend_idx, 0);
        check_output("buy0_credit", credit, 3);
        next_cycle();
        check_output("buy0_pulse_end", vend_valid, 0);
        check_output("buy0_avail", avail, 0);

        apply_stimulus(8'h40);
        check_output("deny_pulse", deny, 1);
        check_output("deny_credit", credit, 3);
        next_cycle();
        check_output("deny_pulse_end", deny, 0);
        apply_stimulus(8'h80);
        check_output("ret_valid", chg_valid, 1);
        check_output("ret_amt", chg_amt, 3);
        check_output("ret_credit", credit, 0);
        next_cycle();
        check_output("ret_amt_idle", chg_amt, 0);
        apply_stimulus(8'h80);
        check_output("ret_zero_nopulse", chg_valid, 0);

        repeat (4) apply_stimulus(8'h08);
        check_output("coin20x4_credit", credit, 80);
        apply_stimulus(8'h04);
        check_output("coin10_credit", credit, 90);
        apply_stimulus(8'h04);
        check_output("coin_rej_pulse", coin_rej, 1);
        check_output("coin_rej_credit", credit, 90);
        apply_stimulus(8'h09);
        check_output("coin_lowest_credit", credit, 91);
        check_output("coin_lowest_norej", coin_rej, 0);
        apply_stimulus(8'h02);
        repeat (3) apply_stimulus(8'h01);
        check_output("coin_at_max_credit", credit, 99);
        check_output("coin_at_max_norej", coin_rej, 0);
        apply_stimulus(8'h01);
        check_output("coin_over_max_rej", coin_rej, 1);
        check_output("coin_over_max_credit", credit, 99);

        apply_stimulus(8'h10);
        check_output("nav_l_wrap", sel_idx, 4);
        check_output("nav_l_price", sel_price, 8);
        apply_stimulus(8'h20);
        check_output("nav_r_wrap", sel_idx, 0);
        apply_stimulus(8'h30);
        check_output("nav_lr_hold", sel_idx, 0);
        apply_stimulus(8'h20);
        check_output("nav_r_step", sel_idx, 1);
        check_output("nav_r_price", sel_price, 5);
        apply_stimulus(8'h40);
        check_output("buy1_idx", vend_idx, 1);
        check_output("buy1_credit", credit, 94);

        apply_stimulus(8'hC1);
        check_output("prio_chg_valid", chg_valid, 1);
        check_output("prio_chg_amt", chg_amt, 94);
        check_output("prio_no_vend", {vend_valid, deny, coin_rej}, 0);
        check_output("prio_credit", credit, 0);
        next_cycle();
        check_output("prio_coin_dropped", credit, 0);

        apply_stimulus(8'h04);
        check_output("pre_reset_credit", credit, 10);
        @(negedge clk);
        coin = 4'b0010;
        @(negedge clk);
        coin = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("midrst_credit", credit, 0);
        check_output("midrst_sel_idx", sel_idx, 0);
        check_output("midrst_pulses", {vend_valid, deny, coin_rej, chg_valid}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) next_cycle();
        check_output("postrst_credit", credit, 0);
        check_output("postrst_avail", avail, 0);
        check_output("postrst_pulses", {vend_valid, deny, coin_rej, chg_valid}, 0);

        $display("%0d/%0d checks passed", pass_count, pass_count + fail_count);
        $finish;
    end

endmodule
